// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter_pkg
// Description : Shared encodings for the core memory-bus arbiter: FSM states,
//               bus owner and transfer size.
// Revision    : 1.0  initial release
// ============================================================================
package mem_bus_arbiter_pkg;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Current bus owner
    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_t;

    // Transfer size encodings shared by the data port and the bus
    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

endpackage : mem_bus_arbiter_pkg
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_bus_arbiter
// Description : Shares one req/addr_ok/data_ok memory bus between the fetch
//               port and the memory-stage port. Data side has priority; a
//               saturating starvation counter forces a waiting fetch through
//               after STARVE_LIMIT data grants. Drives the pending flags used
//               by the pipeline hazard controller.
// Revision    : 1.0  initial release
// ============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int AW           = 32,
    parameter int DW           = 32
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    input  logic          inst_cancel,
    output logic          inst_addr_ok,
    output logic          inst_data_ok,
    output logic [DW-1:0] inst_rdata,

    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic          data_addr_ok,
    output logic          data_data_ok,
    output logic [DW-1:0] data_rdata,

    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata,

    output logic          AddrPendingF,
    output logic          DataPendingF,
    output logic          AddrPendingE,
    output logic          DataPendingM
);

    localparam int            C_CW    = $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CW-1:0] C_LIMIT = C_CW'(STARVE_LIMIT);

    state_t          r_state;
    owner_t          r_owner;
    logic            r_drop;
    logic [C_CW-1:0] r_starve;
    logic            r_bus_req;
    logic            r_bus_wr;
    logic [1:0]      r_bus_size;
    logic [AW-1:0]   r_bus_addr;
    logic [DW-1:0]   r_bus_wdata;
    logic [DW-1:0]   r_inst_rdata;
    logic [DW-1:0]   r_data_rdata;

    logic w_accept;
    logic w_done;
    logic w_force_inst;
    logic w_grant_data;
    logic w_grant_inst;
    logic w_inst_data_ok;
    logic w_data_data_ok;
    logic w_load_ok;
    logic w_addr_pend_f;
    logic w_addr_pend_e;

    // Address handshake only counts in ADDR; completion is either a combined
    // addr+data handshake in ADDR or a data handshake in WAIT. A bus_data_ok
    // seen in IDLE (e.g. a straggler after reset) is ignored.
    assign w_accept = (r_state == ADDR) & bus_addr_ok;
    assign w_done   = (w_accept & bus_data_ok) | ((r_state == WAIT) & bus_data_ok);

    // Grant: data wins unless a waiting fetch has been starved STARVE_LIMIT times
    assign w_force_inst = inst_req & (r_starve == C_LIMIT);
    assign w_grant_data = (r_state == IDLE) & data_req & ~w_force_inst;
    assign w_grant_inst = (r_state == IDLE) & inst_req & ~w_grant_data;

    // Owner handshake pulses pass straight through from the bus; a cancelled
    // fetch (earlier via drop, or in the completion cycle itself) is silent
    assign w_inst_data_ok = w_done & (r_owner == INST) & ~r_drop & ~inst_cancel;
    assign w_data_data_ok = w_done & (r_owner == DATA);
    assign w_load_ok      = w_data_data_ok & ~r_bus_wr;

    assign inst_addr_ok = w_accept & (r_owner == INST);
    assign data_addr_ok = w_accept & (r_owner == DATA);
    assign inst_data_ok = w_inst_data_ok;
    assign data_data_ok = w_data_data_ok;
    assign inst_rdata   = w_inst_data_ok ? bus_rdata : r_inst_rdata;
    assign data_rdata   = w_load_ok      ? bus_rdata : r_data_rdata;

    assign bus_req   = r_bus_req;
    assign bus_wr    = r_bus_wr;
    assign bus_size  = r_bus_size;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;

    // Pending flags; request-side terms are masked while reset is asserted
    assign w_addr_pend_f = rst & inst_req & ~inst_addr_ok;
    assign w_addr_pend_e = rst & data_req & ~data_addr_ok;
    assign AddrPendingF  = w_addr_pend_f;
    assign AddrPendingE  = w_addr_pend_e;
    assign DataPendingF  = w_addr_pend_f |
                           ((r_owner == INST) & (r_state != IDLE) & ~r_drop & ~w_inst_data_ok);
    assign DataPendingM  = w_addr_pend_e |
                           ((r_owner == DATA) & (r_state != IDLE) & ~w_data_data_ok);

    // Arbiter FSM: grant in IDLE, address phase in ADDR, data phase in WAIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_owner     <= INST;
            r_drop      <= 1'b0;
            r_starve    <= '0;
            r_bus_req   <= 1'b0;
            r_bus_wr    <= 1'b0;
            r_bus_size  <= 2'd0;
            r_bus_addr  <= '0;
            r_bus_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_drop <= 1'b0;
                    if (w_grant_data) begin
                        r_owner     <= DATA;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= data_wr;
                        r_bus_size  <= data_size;
                        r_bus_addr  <= data_addr;
                        r_bus_wdata <= data_wdata;
                        r_state     <= ADDR;
                        // A forced fetch implies inst_req=0 here, so the
                        // counter can never step past the limit
                        if (inst_req && (r_starve != C_LIMIT)) begin
                            r_starve <= r_starve + 1'b1;
                        end
                    end else if (w_grant_inst) begin
                        r_owner     <= INST;
                        r_bus_req   <= 1'b1;
                        r_bus_wr    <= 1'b0;
                        r_bus_size  <= SZ_WORD;
                        r_bus_addr  <= inst_addr;
                        r_bus_wdata <= '0;
                        r_starve    <= '0;
                        r_state     <= ADDR;
                    end
                end
                ADDR: begin
                    if ((r_owner == INST) && inst_cancel) begin
                        r_drop <= 1'b1;
                    end
                    if (bus_addr_ok) begin
                        r_bus_req <= 1'b0;
                        if (bus_data_ok) begin
                            r_drop  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if ((r_owner == INST) && inst_cancel) begin
                        r_drop <= 1'b1;
                    end
                    if (bus_data_ok) begin
                        r_drop  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_bus_req <= 1'b0;
                    r_drop    <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Read-data hold registers: keep the last delivered value between pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
        end else begin
            if (w_inst_data_ok) begin
                r_inst_rdata <= bus_rdata;
            end
            if (w_load_ok) begin
                r_data_rdata <= bus_rdata;
            end
        end
    end

endmodule : mem_bus_arbiter
`default_nettype wire

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single core memory bus between the fetch port (inst) and the memory-stage port (data).
- Bus protocol is req / addr_ok / data_ok; one transaction outstanding at a time.
- Generates the pending flags AddrPendingF, DataPendingF, AddrPendingE and DataPendingM consumed by the pipeline hazard controller.
- Data side has priority; a starvation counter bounds fetch latency.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants that lose to a waiting inst request before inst is forced through.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset: asynchronous, active-low
- inst_req  in  1  fetch request; held with inst_addr until inst_addr_ok
- inst_addr  in  AW  fetch address
- inst_cancel  in  1  fetch flush; drop any accepted-but-unreturned fetch
- inst_addr_ok  out  1  fetch address accepted (1-cycle pulse)
- inst_data_ok  out  1  fetch data valid (1-cycle pulse)
- inst_rdata  out  DW  fetch read data
- data_req  in  1  load/store request; held with its fields until data_addr_ok
- data_wr  in  1  1 = store
- data_size  in  2  0 = byte, 1 = half, 2 = word
- data_addr  in  AW  load/store address
- data_wdata  in  DW  store data
- data_addr_ok  out  1  data address accepted (1-cycle pulse)
- data_data_ok  out  1  data complete (1-cycle pulse)
- data_rdata  out  DW  load read data
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus transfer size
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  bus accepted address
- bus_data_ok  in  1  bus returned data / write done
- bus_rdata  in  DW  bus read data
- AddrPendingF  out  1  inst_req high and not yet accepted
- DataPendingF  out  1  fetch in flight (requested or accepted, data not yet returned)
- AddrPendingE  out  1  data_req high and not yet accepted
- DataPendingM  out  1  data access in flight

Behaviour:
- FSM states: IDLE, ADDR, WAIT. Registers: owner (INST/DATA), drop, starve_cnt (width clog2(STARVE_LIMIT+1)), plus registered bus_wr, bus_size, bus_addr, bus_wdata.
- Reset (rst=0, async): state=IDLE, owner=INST, drop=0, starve_cnt=0, bus_req=0; all bus_* registers=0; all *_ok outputs=0; rdata outputs=0.
- IDLE grant:
  - data_req wins, unless inst_req && starve_cnt==STARVE_LIMIT, in which case inst wins.
  - On grant, latch the winner's fields into the bus registers and go to ADDR.
  - bus_req rises the cycle after the requester's req is first seen: 1-cycle grant latency.
- starve_cnt:
  - Increments when data is granted while inst_req=1.
  - Clears when inst is granted.
  - Saturates at STARVE_LIMIT.
- ADDR state:
  - bus_req=1 while in ADDR.
  - On bus_addr_ok, pulse the owner's *_addr_ok in the same cycle; bus_req drops the next cycle.
  - Go to WAIT, or straight to IDLE if bus_data_ok is also high that cycle.
- WAIT state: on bus_data_ok, pass bus_rdata to the owner's rdata and pulse the owner's *_data_ok in the same cycle (combinational pass-through), then go to IDLE.
- Back-to-back requests: the completion cycle never grants; the next request is granted from IDLE one cycle later.
- inst_cancel while owner=INST:
  - In ADDR or WAIT: set drop.
  - Transaction still completes on the bus; inst_data_ok is suppressed when it completes.
  - drop clears on return to IDLE.
  - inst_cancel in IDLE, or while owner=DATA, has no effect.
- inst_cancel and bus_data_ok in the same cycle: data is suppressed.
- The requester's req is ignored while it already owns the bus.
- Pending flags (combinational):
  - AddrPendingF = inst_req & ~inst_addr_ok.
  - DataPendingF = AddrPendingF | (owner==INST & state!=IDLE & ~drop & ~inst_data_ok).
  - AddrPendingE = data_req & ~data_addr_ok.
  - DataPendingM = AddrPendingE | (owner==DATA & state!=IDLE & ~data_data_ok).
  - All four are 0 in reset.
- Reset mid-transaction: everything returns to IDLE immediately. Any late bus_data_ok arriving in IDLE is ignored, with no *_data_ok pulse.
- Stores: bus_rdata is ignored; data_rdata holds its last value.

Decomposition:
- Shared package:
  - State encoding: IDLE=2'd0, ADDR=2'd1, WAIT=2'd2.
  - Owner encoding: INST=1'b0, DATA=1'b1.
  - Size encodings.
- No sub-module. Grant priority logic plus starve counter stays inline; it is under 30 lines.

Test Plan:
- Single fetch: inst_req, addr 0xBFC00000; bus_addr_ok on cycle 2, bus_data_ok on cycle 4 with 0x3C010000 -> bus_req high cycles 1-2; inst_addr_ok pulses cycle 2; inst_data_ok with rdata 0x3C010000 on cycle 4; DataPendingF high cycles 0-3, low on cycle 4.
- Simultaneous requests: inst_req and data_req raised together, data_addr 0x80001000 -> data granted first, inst granted in the IDLE cycle after data_data_ok; AddrPendingF stays high throughout.
- Starvation: data_req held continuously with inst_req high, STARVE_LIMIT=4 -> 4 data transactions, then inst granted on the 5th grant; starve_cnt returns to 0.
- Cancel: inst_cancel asserted in WAIT -> bus transaction completes, inst_data_ok stays 0, DataPendingF drops the cycle after cancel; the following data_req is served normally.
- Zero-wait bus: bus_addr_ok and bus_data_ok both asserted the first cycle bus_req is high -> both owner pulses in the same cycle; FSM returns to IDLE and the next grant comes one cycle later.
- Async reset: rst pulled low mid-WAIT -> bus_req=0 and all flags 0 immediately; a bus_data_ok arriving after reset releases produces no *_data_ok.
